alu_core: RTL and testbench

- Registered, single-cycle-latency arithmetic/logic unit with status flags.
- Each clock it samples two operands and an opcode, then registers result, zero, carry and error flags.
- Sits behind a simple signal-bundle interface in the block-level environment.
- No handshake: a new operation may be presented every cycle.

---
 rtl/alu_core.sv | 104 ++++++++++
 tb/tb_alu_core.sv | 128 ++++++++++++
 2 files changed

// File: rtl/alu_core.sv
// rtl/alu_core.sv - registered single-cycle ALU with zero, carry and error flags
module alu_core #(
    parameter int WIDTH = 8,
    parameter int OP_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             carry_o,
    output logic             error_o
);

    localparam logic [OP_W-1:0] OP_ADD = 4'h0;
    localparam logic [OP_W-1:0] OP_SUB = 4'h1;
    localparam logic [OP_W-1:0] OP_AND = 4'h2;
    localparam logic [OP_W-1:0] OP_OR  = 4'h3;
    localparam logic [OP_W-1:0] OP_XOR = 4'h4;
    localparam logic [OP_W-1:0] OP_NOT = 4'h5;
    localparam logic [OP_W-1:0] OP_SHL = 4'h6;
    localparam logic [OP_W-1:0] OP_SHR = 4'h7;
    localparam logic [OP_W-1:0] OP_INC = 4'h8;
    localparam logic [OP_W-1:0] OP_DEC = 4'h9;
    localparam logic [OP_W-1:0] OP_MUL = 4'hA;
    localparam logic [OP_W-1:0] OP_DIV = 4'hB;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               error_q, error_d;

    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     inc_w;
    logic [2*WIDTH-1:0] prod_w;
    logic [WIDTH-1:0]   divisor_w;
    logic [WIDTH-1:0]   res_w;
    logic               cy_w;
    logic               err_w;

    always_comb begin
        sum_w     = {1'b0, a_i} + {1'b0, b_i};
        inc_w     = {1'b0, a_i} + {1'b0, ONE};
        prod_w    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        // Keeps the divider free of a zero divisor; the b==0 case is flagged as an error anyway.
        divisor_w = (b_i == ZERO) ? ONE : b_i;

        res_w = ZERO;
        cy_w  = 1'b0;
        err_w = 1'b0;
        case (op_i)
            OP_ADD: begin res_w = sum_w[WIDTH-1:0]; cy_w = sum_w[WIDTH]; end
            OP_SUB: begin res_w = a_i - b_i; cy_w = (a_i < b_i); end
            OP_AND: res_w = a_i & b_i;
            OP_OR:  res_w = a_i | b_i;
            OP_XOR: res_w = a_i ^ b_i;
            OP_NOT: res_w = ~a_i;
            OP_SHL: begin res_w = {a_i[WIDTH-2:0], 1'b0}; cy_w = a_i[WIDTH-1]; end
            OP_SHR: begin res_w = {1'b0, a_i[WIDTH-1:1]}; cy_w = a_i[0]; end
            OP_INC: begin res_w = inc_w[WIDTH-1:0]; cy_w = inc_w[WIDTH]; end
            OP_DEC: begin res_w = a_i - ONE; cy_w = (a_i == ZERO); end
            OP_MUL: begin res_w = prod_w[WIDTH-1:0]; cy_w = |prod_w[2*WIDTH-1:WIDTH]; end
            OP_DIV: begin res_w = a_i / divisor_w; err_w = (b_i == ZERO); end
            default: err_w = 1'b1;
        endcase

        if (err_w) begin
            result_d = ZERO;
            carry_d  = 1'b0;
            zero_d   = 1'b0;
            error_d  = 1'b1;
        end else begin
            result_d = res_w;
            carry_d  = cy_w;
            zero_d   = (res_w == ZERO);
            error_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= ZERO;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            error_q  <= error_d;
        end
    end

    assign result_o = result_q;
    assign zero_o   = zero_q;
    assign carry_o  = carry_q;
    assign error_o  = error_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed vector bench for alu_core
module tb_alu_core;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             carry_o;
    logic             error_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] op;
        logic [7:0] res;
        logic       z;
        logic       c;
        logic       e;
    } vec_t;

    vec_t vecs[$];

    alu_core #(.WIDTH(WIDTH), .OP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .a_i      (a_i),
        .b_i      (b_i),
        .op_i     (op_i),
        .result_o (result_o),
        .zero_o   (zero_o),
        .carry_o  (carry_o),
        .error_o  (error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] res,
                         input logic z, input logic c, input logic e);
        total++;
        if (result_o !== res || zero_o !== z || carry_o !== c || error_o !== e) begin
            bad++;
            $display("FAIL %s: got res=%02h z=%0b c=%0b e=%0b, want res=%02h z=%0b c=%0b e=%0b",
                     name, result_o, zero_o, carry_o, error_o, res, z, c, e);
        end
    endtask

    task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                           input logic [7:0] res, input logic z, input logic c, input logic e);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.res = res; v.z = z; v.c = c; v.e = e;
        vecs.push_back(v);
    endtask

    initial begin
        //        a      b      op    res    z     c     e
        add_vec(8'h12, 8'h34, 4'h0, 8'h46, 1'b0, 1'b0, 1'b0);
        add_vec(8'h10, 8'h20, 4'h1, 8'hF0, 1'b0, 1'b1, 1'b0);
        add_vec(8'hA5, 8'h0F, 4'h2, 8'h05, 1'b0, 1'b0, 1'b0);
        add_vec(8'hA5, 8'h0F, 4'h3, 8'hAF, 1'b0, 1'b0, 1'b0);
        add_vec(8'hA5, 8'h0F, 4'h4, 8'hAA, 1'b0, 1'b0, 1'b0);
        add_vec(8'hA5, 8'h0F, 4'h5, 8'h5A, 1'b0, 1'b0, 1'b0);
        add_vec(8'h81, 8'h33, 4'h6, 8'h02, 1'b0, 1'b1, 1'b0);
        add_vec(8'h81, 8'h33, 4'h7, 8'h40, 1'b0, 1'b1, 1'b0);
        add_vec(8'hFF, 8'h77, 4'h8, 8'h00, 1'b1, 1'b1, 1'b0);
        add_vec(8'h00, 8'h77, 4'h9, 8'hFF, 1'b0, 1'b1, 1'b0);
        add_vec(8'h10, 8'h10, 4'hA, 8'h00, 1'b1, 1'b1, 1'b0);
        add_vec(8'h64, 8'h07, 4'hB, 8'h0E, 1'b0, 1'b0, 1'b0);
        add_vec(8'h64, 8'h00, 4'hB, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(8'hA5, 8'h5A, 4'hC, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(8'hFF, 8'hFF, 4'hD, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(8'h00, 8'h00, 4'hE, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(8'h12, 8'h34, 4'hF, 8'h00, 1'b0, 1'b0, 1'b1);
        add_vec(8'h01, 8'h01, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0);
        add_vec(8'h0F, 8'h0F, 4'hA, 8'hE1, 1'b0, 1'b0, 1'b0);
        add_vec(8'h05, 8'h05, 4'h1, 8'h00, 1'b1, 1'b0, 1'b0);
        add_vec(8'h80, 8'h80, 4'h0, 8'h00, 1'b1, 1'b1, 1'b0);
        add_vec(8'h07, 8'h08, 4'hB, 8'h00, 1'b1, 1'b0, 1'b0);
        add_vec(8'h40, 8'h00, 4'h6, 8'h80, 1'b0, 1'b0, 1'b0);
        add_vec(8'h80, 8'h00, 4'h8, 8'h81, 1'b0, 1'b0, 1'b0);

        rst  = 1'b1;
        a_i  = 8'hFF;
        b_i  = 8'h01;
        op_i = 4'h0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check($sformatf("reset_%0d", i), 8'h00, 1'b0, 1'b0, 1'b0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset_add", 8'h00, 1'b1, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            a_i  = vecs[i].a;
            b_i  = vecs[i].b;
            op_i = vecs[i].op;
            @(posedge clk); #1;
            check($sformatf("vec_%0d_op%0h", i, vecs[i].op),
                  vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].e);
        end

        // Error set, then a mid-stream reset discards the operation sampled with it.
        a_i = 8'h01; b_i = 8'h00; op_i = 4'hB;
        @(posedge clk); #1;
        check("div0_before_reset", 8'h00, 1'b0, 1'b0, 1'b1);
        rst = 1'b1; a_i = 8'h12; b_i = 8'h34; op_i = 4'h0;
        @(posedge clk); #1;
        check("midstream_reset", 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; a_i = 8'hFF; op_i = 4'h8;
        @(posedge clk); #1;
        check("after_midstream_reset", 8'h00, 1'b1, 1'b1, 1'b0);
        a_i = 8'h03; b_i = 8'h04; op_i = 4'h0;
        @(posedge clk); #1;
        check("back_to_back_add", 8'h07, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
